debounce_pulse: RTL and testbench
=================================

Name: debounce_pulse

Overview:
Upstream conditioning stage for the D flip-flop and register stages in the practice designs. Takes a raw, bouncing, asynchronous pushbutton/switch input and synchronises it to clk. It debounces the input with a counter-based state machine. Outputs are a clean level, usable as D, and single-cycle rise/fall pulses, usable as enable, plus a saturating count of rejected bounces for lab observation.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a new level; legal range 2 .. 2^CNT_W.
- CNT_W, 16, width of the stability counter.
- BOUNCE_W, 8, width of the rejected-bounce counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- btn_in  input  1  raw asynchronous switch input.
- level_out  output  1  debounced level.
- rise_pulse  output  1  one-cycle pulse when level_out goes 0->1.
- fall_pulse  output  1  one-cycle pulse when level_out goes 1->0.
- busy  output  1  high while in a CHECK state.
- bounce_cnt  output  BOUNCE_W  number of aborted checks; saturates at all-ones.

Behaviour:
- Synchroniser: two flip-flops, sync1 <= btn_in, then sync <= sync1. The FSM uses only sync.
- States: IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW. Registers: state, cnt[CNT_W], level_out, rise_pulse, fall_pulse, bounce_cnt.
- Reset (async, any time including mid-check):
  - sync1 = 0, sync = 0, state = IDLE_LOW, cnt = 0.
  - level_out = 0, rise_pulse = 0, fall_pulse = 0, bounce_cnt = 0.
  - After release, normal operation starts on the first rising edge. A btn_in held high during reset is then accepted through the normal CHECK_HIGH path.
- Per clock edge, default rise_pulse = 0 and fall_pulse = 0, so each pulse lasts exactly 1 cycle.
- IDLE_LOW:
  - sync = 1 -> CHECK_HIGH, cnt <= 0.
  - Otherwise stay.
- CHECK_HIGH:
  - sync = 0 -> IDLE_LOW, cnt <= 0, bounce_cnt++ (saturating).
  - Else if cnt == DEBOUNCE_CYCLES-1 -> IDLE_HIGH, level_out <= 1, rise_pulse <= 1, cnt <= 0.
  - Else cnt <= cnt+1.
- IDLE_HIGH and CHECK_LOW mirror IDLE_LOW and CHECK_HIGH with polarity inverted; acceptance drives level_out <= 0 and fall_pulse <= 1.
- busy = 1 exactly when state is CHECK_HIGH or CHECK_LOW (combinational from state).
- Latency:
  - Let e1 be the first rising edge that samples the new btn_in value into sync1. Then sync updates at e1+1, CHECK is entered at e1+2, and level_out/pulse assert at edge e1+2+DEBOUNCE_CYCLES.
  - A stable input therefore needs sync to hold for DEBOUNCE_CYCLES+1 consecutive sampled cycles (entry cycle plus DEBOUNCE_CYCLES checks).
- Abort: any opposite sample during CHECK returns to the prior IDLE state. level_out is unchanged, no pulse is issued, and bounce_cnt increments unless it is already all-ones.
- Retrigger: after an abort, a new CHECK restarts from cnt = 0. The counter never accumulates across aborts.
- rise_pulse and fall_pulse are never high in the same cycle. Consecutive pulses are at least DEBOUNCE_CYCLES+1 cycles apart.
- cnt never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible for legal parameters.

Test Plan:
1. DEBOUNCE_CYCLES=4. Apply reset, release, hold btn_in=0 for 20 cycles -> level_out=0, no pulses, busy=0, bounce_cnt=0.
2. DEBOUNCE_CYCLES=4. Clean press: btn_in 0->1 sampled at edge e1 and held -> busy=1 from e1+2; level_out=1 and rise_pulse=1 at e1+6; rise_pulse=0 at e1+7; busy=0 from e1+6.
3. DEBOUNCE_CYCLES=4. Bounce during press: btn_in pattern 1,1,0,1,0,1 then held 1, each sample lasting one cycle -> bounce_cnt=2. Exactly one rise_pulse, occurring 6 edges after the last 0->1 sample edge.
4. From level_out=1, clean release held -> fall_pulse for exactly 1 cycle, level_out=0, rise_pulse stays 0 throughout.
5. Assert reset asynchronously (between edges) while in CHECK_HIGH with cnt=2 -> all outputs 0 immediately, without waiting for an edge. After release with btn_in still 1 -> full 4-cycle check repeats, then rise_pulse.
6. BOUNCE_W=2: generate 5 aborted checks -> bounce_cnt reads 1, 2, 3, 3, 3 (saturates, no wrap).

Source files
------------

// File: rtl/debounce_pulse_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | debounce_pulse_if                                                          |
// | Pushbutton input and conditioned outputs of the debounce stage.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface debounce_pulse_if #(
  parameter int BOUNCE_W = 8
);
  logic                btn_in;
  logic                level_out;
  logic                rise_pulse;
  logic                fall_pulse;
  logic                busy;
  logic [BOUNCE_W-1:0] bounce_cnt;

  modport master (
    output btn_in,
    input  level_out, rise_pulse, fall_pulse, busy, bounce_cnt
  );

  modport slave (
    input  btn_in,
    output level_out, rise_pulse, fall_pulse, busy, bounce_cnt
  );
endinterface
`default_nettype wire

// File: rtl/debounce_pulse.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | debounce_pulse                                                             |
// | Synchronises and debounces a raw switch; clean level, edge pulses, bounces.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int BOUNCE_W        = 8
) (
  input  wire logic          clk,
  input  wire logic          reset,
  debounce_pulse_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]    c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    c_CNT_ONE  = CNT_W'(1);
  localparam logic [BOUNCE_W-1:0] c_BNC_ONE  = BOUNCE_W'(1);

  logic                r_sync1;
  logic                r_sync;
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_level;
  logic                r_rise;
  logic                r_fall;
  logic [BOUNCE_W-1:0] r_bounce;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_level_nxt;
  logic                w_rise_nxt;
  logic                w_fall_nxt;
  logic                w_abort;
  logic [BOUNCE_W-1:0] w_bounce_nxt;

  // Two-flop synchroniser; only r_sync is ever seen by the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync  <= 1'b0;
    end else begin
      r_sync1 <= bus.btn_in;
      r_sync  <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE_LOW;
      r_cnt    <= '0;
      r_level  <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_bounce <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_level  <= w_level_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
      r_bounce <= w_bounce_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      IDLE_LOW: begin
        if (r_sync) begin
          w_state_nxt = CHECK_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      CHECK_HIGH: begin
        if (!r_sync) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!r_sync) begin
          w_state_nxt = CHECK_LOW;
          w_cnt_nxt   = '0;
        end
      end
      CHECK_LOW: begin
        if (r_sync) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Bounce counter holds at all-ones rather than wrapping.
  always_comb begin
    w_bounce_nxt = r_bounce;
    if (w_abort && (r_bounce != '1)) begin
      w_bounce_nxt = r_bounce + c_BNC_ONE;
    end
  end

  assign bus.level_out  = r_level;
  assign bus.rise_pulse = r_rise;
  assign bus.fall_pulse = r_fall;
  assign bus.busy       = (r_state == CHECK_HIGH) || (r_state == CHECK_LOW);
  assign bus.bounce_cnt = r_bounce;

endmodule
`default_nettype wire

// File: tb/tb_debounce_pulse.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_debounce_pulse                                                          |
// | Table-driven and directed checks of debounce_pulse with 4-cycle debounce.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_debounce_pulse;

  localparam int DC = 4;
  localparam int BW = 2;

  typedef struct {
    int btn;
    int level;
    int rise;
    int fall;
    int busy;
    int bounce;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  vec_t q[$];

  debounce_pulse_if #(.BOUNCE_W(BW)) bus ();

  debounce_pulse #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (3),
    .BOUNCE_W       (BW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int b, input int l, input int r, input int f,
                     input int by, input int bc);
    vec_t v;
    v.btn = b; v.level = l; v.rise = r; v.fall = f; v.busy = by; v.bounce = bc;
    q.push_back(v);
  endtask

  task automatic chk_all(input string tag, input int l, input int r, input int f,
                         input int by, input int bc);
    chk({tag, ".level"},  int'(bus.level_out),  l);
    chk({tag, ".rise"},   int'(bus.rise_pulse), r);
    chk({tag, ".fall"},   int'(bus.fall_pulse), f);
    chk({tag, ".busy"},   int'(bus.busy),       by);
    chk({tag, ".bounce"}, int'(bus.bounce_cnt), bc);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < q.size(); i++) begin
      bus.btn_in = q[i].btn[0];
      tick();
      chk_all($sformatf("%s[%0d]", tag, i), q[i].level, q[i].rise, q[i].fall,
              q[i].busy, q[i].bounce);
    end
    q.delete();
  endtask

  // Clean transition: two synchroniser cycles, DC busy cycles, then one pulse.
  task automatic add_clean(input int b, input int bc);
    int old_l;
    old_l = 1 - b;
    add(b, old_l, 0, 0, 0, bc);
    add(b, old_l, 0, 0, 0, bc);
    for (int k = 0; k < DC; k++) add(b, old_l, 0, 0, 1, bc);
    add(b, b, b, 1 - b, 0, bc);
    add(b, b, 0, 0, 0, bc);
    add(b, b, 0, 0, 0, bc);
  endtask

  initial begin
    int sat_exp[5];
    n_cmp = 0;
    n_err = 0;
    sat_exp = '{1, 2, 3, 3, 3};
    reset = 1'b1;
    bus.btn_in = 1'b0;
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Idle low for 20 cycles
    for (int k = 0; k < 20; k++) add(0, 0, 0, 0, 0, 0);
    run_table("idle");

    add_clean(1, 0);
    run_table("press");
    add_clean(0, 0);
    run_table("release");

    // Bounce 1,1,0,1,0,1 then held: two aborts, one rise 6 edges after last 0->1
    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 1, 2);
    add(1, 0, 0, 0, 1, 2);
    add(1, 0, 0, 0, 1, 2);
    add(1, 0, 0, 0, 1, 2);
    add(1, 1, 1, 0, 0, 2);
    add(1, 1, 0, 0, 0, 2);
    run_table("bounce");

    add_clean(0, 2);
    run_table("release2");

    // Enter CHECK_HIGH and reach cnt=2, then reset between edges
    for (int k = 0; k < 5; k++) begin
      bus.btn_in = 1'b1;
      tick();
    end
    chk("pre_areset.busy", int'(bus.busy), 1);
    chk("pre_areset.bounce", int'(bus.bounce_cnt), 2);
    #2;
    reset = 1'b1;
    #1;
    chk_all("areset", 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    add_clean(1, 0);
    run_table("after_reset");

    // Saturation: five aborted checks from a fresh reset
    reset = 1'b1;
    bus.btn_in = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.btn_in = 1'b1;
      tick();
      bus.btn_in = 1'b0;
      tick();
      tick();
      tick();
      chk($sformatf("sat[%0d].bounce", i), int'(bus.bounce_cnt), sat_exp[i]);
      chk($sformatf("sat[%0d].level", i), int'(bus.level_out), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
